gestor_salidas_bus: RTL and testbench

//  Registered, parametrised output manager between the MicroUAZ datapath and the external memory bus.
//  Per access, maps Sel_Salidas to data, address and read/write, the same as the combinational output stage.

---
 rtl/salidas_pkg.sv | 15 +
 rtl/contador_espera.sv | 32 +++
 rtl/gestor_salidas_bus.sv | 146 ++++++++++++++
 tb/tb_gestor_salidas_bus.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/salidas_pkg.sv
// Shared types for the bus output manager: FSM state encoding and Sel_Salidas codes.
package salidas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] SEL_NOP    = 2'b00;
  localparam logic [1:0] SEL_RD     = 2'b01;
  localparam logic [1:0] SEL_WR_NUM = 2'b10;
  localparam logic [1:0] SEL_WR_RX  = 2'b11;

endpackage

// File: rtl/contador_espera.sv
// Clearable up-counter that flags expiry once TIMEOUT_CYC counted cycles have elapsed.
module contador_espera #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry is raised during the TIMEOUT_CYC-th enabled cycle so the owner can act on that edge.
  assign o_Expired = i_En && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr)
      cnt_d = '0;
    else if (i_En && !o_Expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gestor_salidas_bus.sv
// Registered bus output manager with req/ack handshake and read-data capture.
// Define GESTOR_SALIDAS_TIMEOUT_EN to add the ack watchdog (contador_espera).
module gestor_salidas_bus
  import salidas_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int RY_W        = 3,
  parameter int NUM_W       = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic [1:0]        Sel_Salidas,
  input  logic [DATA_W-1:0] RX,
  input  logic [RY_W-1:0]   RY,
  input  logic [NUM_W-1:0]  Num,
  input  logic              i_Ack,
  input  logic [DATA_W-1:0] i_Datain,
  output logic [DATA_W-1:0] o_Dataout,
  output logic [DATA_W-1:0] o_Addressdata,
  output logic              o_ReadWrite,
  output logic              o_Req,
  output logic [DATA_W-1:0] o_ReadData,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Timeout
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              expired;

`ifdef GESTOR_SALIDAS_TIMEOUT_EN
  logic tmo_q, tmo_d;

  contador_espera #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_contador_espera (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Clr     (state_q != ACCESS),
    .i_En      (state_q == ACCESS),
    .o_Expired (expired)
  );

  assign o_Timeout = tmo_q;
`else
  assign expired   = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  assign o_Dataout     = data_q;
  assign o_Addressdata = addr_q;
  assign o_ReadWrite   = rw_q;
  assign o_ReadData    = rdata_q;
  assign o_Req         = (state_q == ACCESS);
  assign o_Busy        = (state_q == ACCESS) || (state_q == DONE);
  assign o_Done        = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
`ifdef GESTOR_SALIDAS_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_Start) begin
          case (Sel_Salidas)
            SEL_RD: begin
              addr_d = DATA_W'(RY);
              data_d = '0;
              rw_d   = 1'b0;
            end
            SEL_WR_NUM: begin
              addr_d = RX;
              data_d = DATA_W'(Num);
              rw_d   = 1'b1;
            end
            SEL_WR_RX: begin
              addr_d = DATA_W'(RY);
              data_d = RX;
              rw_d   = 1'b1;
            end
            default: begin
              addr_d = '0;
              data_d = '0;
              rw_d   = 1'b0;
            end
          endcase
          // A NOP completes without ever raising o_Req.
          state_d = (Sel_Salidas == SEL_NOP) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        // Ack takes priority over a simultaneous watchdog expiry.
        if (i_Ack) begin
          if (!rw_q) rdata_d = i_Datain;
          state_d = DONE;
        end else if (expired) begin
`ifdef GESTOR_SALIDAS_TIMEOUT_EN
          tmo_d   = 1'b1;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        addr_d  = '0;
        data_d  = '0;
        rw_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
`ifdef GESTOR_SALIDAS_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
`ifdef GESTOR_SALIDAS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_gestor_salidas_bus.sv
// Scoreboard bench for gestor_salidas_bus; watchdog scenario runs when GESTOR_SALIDAS_TIMEOUT_EN is defined.
module tb_gestor_salidas_bus;

  localparam int TCYC = 4;
`ifdef GESTOR_SALIDAS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rw;
    logic [7:0] rdata;
    logic       tmo;
  } obs_t;

  logic       i_Clk, i_Reset, i_Start, i_Ack;
  logic [1:0] Sel_Salidas;
  logic [7:0] RX, i_Datain;
  logic [2:0] RY, Num;
  logic [7:0] o_Dataout, o_Addressdata, o_ReadData;
  logic       o_ReadWrite, o_Req, o_Busy, o_Done, o_Timeout;

  gestor_salidas_bus #(
    .DATA_W (8), .RY_W (3), .NUM_W (3), .TIMEOUT_CYC (TCYC)
  ) dut (
    .i_Clk (i_Clk), .i_Reset (i_Reset), .i_Start (i_Start),
    .Sel_Salidas (Sel_Salidas), .RX (RX), .RY (RY), .Num (Num),
    .i_Ack (i_Ack), .i_Datain (i_Datain),
    .o_Dataout (o_Dataout), .o_Addressdata (o_Addressdata), .o_ReadWrite (o_ReadWrite),
    .o_Req (o_Req), .o_ReadData (o_ReadData), .o_Busy (o_Busy),
    .o_Done (o_Done), .o_Timeout (o_Timeout)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int         n_vec, n_err;
  obs_t       exp_q[$];
  logic [7:0] model_rdata;
  int         reqs, lat;
  obs_t       got;
  bit         stable, done_busy;

  // Drives one access, pushes its expected result, and records what the DUT did.
  task automatic access(input logic [1:0] sel, input logic [7:0] rx, input logic [2:0] ry,
                        input logic [2:0] num, input int ack_at, input logic [7:0] din, input bit noise);
    obs_t e;
    bit acked;
    logic [7:0] a0;
    e = '0;
    a0 = '0;
    acked = (ack_at > 0) && (!TMO_EN || ack_at <= TCYC);
    case (sel)
      2'b01: e.addr = {5'b0, ry};
      2'b10: begin e.addr = rx; e.data = {5'b0, num}; e.rw = 1'b1; end
      2'b11: begin e.addr = {5'b0, ry}; e.data = rx; e.rw = 1'b1; end
      default: ;
    endcase
    if (sel == 2'b01 && acked) model_rdata = din;
    e.rdata = model_rdata;
    e.tmo = (sel != 2'b00) && !acked;
    exp_q.push_back(e);
    @(negedge i_Clk);
    Sel_Salidas = sel; RX = rx; RY = ry; Num = num; i_Start = 1'b1;
    reqs = 0; lat = 0; got = '0; stable = 1'b1; done_busy = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_Clk);
      i_Start = 1'b0; i_Ack = 1'b0;
      if (o_Done) begin
        lat = c;
        got = {o_Addressdata, o_Dataout, o_ReadWrite, o_ReadData, o_Timeout};
        done_busy = o_Busy && !o_Req;
        break;
      end
      if (o_Req) begin
        reqs++;
        if (reqs == 1) a0 = o_Addressdata;
        else if (o_Addressdata !== a0) stable = 1'b0;
        if (noise) begin i_Start = 1'b1; Sel_Salidas = 2'b01; RY = 3'd7; end
        if (reqs == ack_at) begin i_Ack = 1'b1; i_Datain = din; end
      end
    end
  endtask

  task automatic check_result(input string name, input int exp_reqs, input int exp_lat);
    obs_t e;
    e = exp_q.pop_front();
    n_vec++;
    if (lat == 0) begin
      n_err++; $display("FAIL %s_timeout no o_Done within bound", name);
    end else if (got !== e) begin
      n_err++; $display("FAIL %s_result got %h expected %h", name, got, e);
    end
    n_vec++;
    if (reqs !== exp_reqs || lat !== exp_lat) begin
      n_err++; $display("FAIL %s_timing reqs=%0d lat=%0d expected reqs=%0d lat=%0d", name, reqs, lat, exp_reqs, exp_lat);
    end
    n_vec++;
    if (!done_busy || !stable) begin
      n_err++; $display("FAIL %s_status busy_at_done=%0b addr_stable=%0b expected 1 1", name, done_busy, stable);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({o_Dataout, o_Addressdata, o_ReadWrite, o_Req, o_ReadData, o_Busy, o_Done, o_Timeout} !== '0) begin
      n_err++; $display("FAIL reset_outputs got req=%b busy=%b done=%b addr=%h expected all 0", o_Req, o_Busy, o_Done, o_Addressdata);
    end
  endtask

  task automatic test_read();
    access(2'b01, 8'h00, 3'd5, 3'd0, 3, 8'hA7, 1'b0);
    check_result("read", 3, 4);
  endtask

  task automatic test_write_num();
    access(2'b10, 8'h3C, 3'd1, 3'd6, 1, 8'hEE, 1'b0);
    check_result("write_num", 1, 2);
    @(negedge i_Clk);
    n_vec++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0 || o_Addressdata !== 8'h00 || o_Dataout !== 8'h00) begin
      n_err++; $display("FAIL idle_park busy=%b done=%b addr=%h data=%h expected 0 0 00 00", o_Busy, o_Done, o_Addressdata, o_Dataout);
    end
  endtask

  task automatic test_nop_ignored_start();
    access(2'b00, 8'h55, 3'd3, 3'd2, 0, 8'h00, 1'b0);
    check_result("nop", 0, 1);
    access(2'b11, 8'h42, 3'd4, 3'd0, 3, 8'h00, 1'b1);
    check_result("ignored_start", 3, 4);
    @(negedge i_Clk);
    n_vec++;
    if (o_Req !== 1'b0 || o_Busy !== 1'b0) begin
      n_err++; $display("FAIL no_retrigger req=%b busy=%b expected 0 0", o_Req, o_Busy);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge i_Clk);
    Sel_Salidas = 2'b01; RY = 3'd3; i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    n_vec++;
    if (o_Req !== 1'b1) begin
      n_err++; $display("FAIL mid_req got %b expected 1", o_Req);
    end
    #2 i_Reset = 1'b1;
    #1;
    test_reset();
    model_rdata = 8'h00;
    @(negedge i_Clk);
    i_Reset = 1'b0;
    access(2'b11, 8'h99, 3'd2, 3'd0, 1, 8'h00, 1'b0);
    check_result("after_reset", 1, 2);
  endtask

  task automatic test_back_to_back();
    access(2'b01, 8'h00, 3'd6, 3'd0, 2, 8'h5A, 1'b0);
    check_result("b2b_read", 2, 3);
    access(2'b10, 8'hC3, 3'd0, 3'd7, 1, 8'h11, 1'b0);
    check_result("b2b_write", 1, 2);
  endtask

`ifdef GESTOR_SALIDAS_TIMEOUT_EN
  task automatic test_timeout();
    access(2'b01, 8'h00, 3'd4, 3'd0, 0, 8'h55, 1'b0);
    check_result("timeout", TCYC, TCYC + 1);
    access(2'b01, 8'h00, 3'd6, 3'd0, TCYC, 8'h3E, 1'b0);
    check_result("ack_at_expiry", TCYC, TCYC + 1);
  endtask
`else
  task automatic test_timeout();
    access(2'b01, 8'h00, 3'd4, 3'd0, 10, 8'h66, 1'b0);
    check_result("long_wait", 10, 11);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; model_rdata = 8'h00;
    i_Reset = 1'b1; i_Start = 1'b0; i_Ack = 1'b0; Sel_Salidas = 2'b00;
    RX = '0; RY = '0; Num = '0; i_Datain = '0;
    repeat (3) @(negedge i_Clk);
    test_reset();
    i_Reset = 1'b0;
    test_read();
    test_write_num();
    test_nop_ignored_start();
    test_reset_mid_access();
    test_back_to_back();
    test_timeout();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
